conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Streaming sliding-window generator at the head of `cnn_top`. Accepts the raster-order pixel stream from the feature-map feeder (one pixel per `i_in_valid` cycle, row-major, IX×IY per frame) and emits every complete KY×KX convolution window (no padding, stride 1) to the first convolution stage. Internally it holds KY-1 full-row line buffers plus a KY×KX register window.

## Interface
- `I_F_BW`, 8: pixel width in bits
- `IX`, 28: frame width in pixels
- `IY`, 28: frame height in pixels
- `KX`, 5: window width
- `KY`, 5: window height
- `clk`  in  1: clock, rising edge
- `reset_n`  in  1: asynchronous, active-low reset
- `i_in_valid`  in  1: `i_pixel` is valid this cycle; no back-pressure, gaps allowed
- `i_pixel`  in  I_F_BW: input pixel, raster order
- `o_window`  out  KY*KX*I_F_BW: window; element (r,c) at bits `[(r*KX+c)*I_F_BW +: I_F_BW]`, r=0 top (oldest) row, c=0 leftmost
- `o_window_valid`  out  1: `o_window` holds a complete window this cycle
- `o_win_row`  out  clog2(IY): output row of the window (top-left image row)
- `o_win_col`  out  clog2(IX): output column of the window (top-left image column)
- `o_frame_done`  out  1: one-cycle pulse, last pixel of frame consumed

## Operation
- Counters `col` (0..IX-1) and `row` (0..IY-1) track the position of the incoming pixel. They advance only on `i_in_valid`. `col` wraps to 0 and increments `row`. After (IY-1, IX-1) both return to 0; the next valid pixel starts a new frame.
- On each accepted pixel:
  - Every window row shifts left by one.
  - Column KX-1 of window row r loads line buffer r output for r<KY-1; row KY-1 loads `i_pixel`.
  - Line buffers cascade: the input feeds buffer KY-2, and buffer k's output feeds buffer k-1. Each buffer has depth IX.
- Window valid condition: accepted pixel has `row >= KY-1` and `col >= KX-1`.
  - On valid, element (r,c) = image pixel (row-KY+1+r, col-KX+1+c).
  - `o_win_row` = row-KY+1; `o_win_col` = col-KX+1.
- Windows per frame: (IX-KX+1)*(IY-KY+1), which is 576 at defaults. Order is raster by (o_win_row, o_win_col).
- Windows never straddle frames: rows 0..KY-2 of a new frame refill the line buffers before any window is valid. Windows never straddle rows because of the `col >= KX-1` gate.
- No flush or clear is required between frames; the counters alone define frame boundaries.
- Line buffer and window storage contents are not reset. Their contents are don't-care until gated by valid.

## Timing
- Reset values: `o_window_valid`=0, `o_frame_done`=0, `o_window`=0, `o_win_row`=0, `o_win_col`=0. Counters reset to 0.
- Latency: all outputs are registered and appear in the cycle after the qualifying pixel is accepted (1 cycle).
- `o_window_valid` is high for exactly one cycle per window. It is low in any cycle following `i_in_valid`=0.
- `o_window`, `o_win_row` and `o_win_col` hold their last value while valid is low.
- `o_frame_done` is asserted in the cycle after pixel (IY-1, IX-1) is accepted. It coincides with the final `o_window_valid` of the frame.
- Input gaps: the output sequence is identical for any `i_in_valid` duty pattern; only its timing stretches.
- Reset mid-frame:
  - Counters return to 0 immediately and outputs drop to reset values asynchronously.
  - The next accepted pixel is treated as (0,0).
  - No stale window may be emitted.
- Sustained throughput: one pixel per cycle, one window per cycle.

## Structure
- Shared package/defines file `cnn_pkg`:
  - holds `I_F_BW`, `IX`, `IY`, `KX`, `KY` defaults;
  - derived `OX = IX-KX+1` and `OY = IY-KY+1`;
  - counter widths.
  - The feeder and the conv stage use the same constants.
- Sub-module `line_buffer_row`:
  - single-row delay of depth IX and width I_F_BW;
  - shifts on enable;
  - inferred as SRL/distributed RAM with a circular pointer.
  - Instantiated KY-1 times.
- Top holds the counters, window registers and output registering.

## Test plan
- Ramp frame, contiguous valid: pixel k = k mod 256, 784 pixels.
  - First `o_window_valid` one cycle after pixel 116 is accepted.
  - That window has (0,0)=0, (0,4)=4, (4,0)=112, (4,4)=116, with win_row/win_col=0/0.
  - Exactly 576 valids; the last window has (4,4)=783 mod 256=15, with win_row/win_col=23/23.
- Same ramp with `i_in_valid` randomly deasserted ~40% of cycles → window sequence identical to the contiguous run.
- `o_frame_done` pulses exactly once, in the same cycle as the 576th valid. It is not asserted for any other pixel.
- Two back-to-back frames (frame 2 = 255-k):
  - the first window of frame 2 has (0,0)=255 and (4,4)=139;
  - no frame-1 pixels appear in any frame-2 window;
  - 1152 valids total.
- Reset pulse after 300 pixels, then a full ramp frame:
  - no valid during or after reset until pixel 116 of the new frame;
  - then exactly 576 windows and one `o_frame_done`.
- Parameter sweep KX=KY=3, IX=IY=8: 36 windows; the first window follows input index 18 and has (2,2)=18.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants for the CNN pipeline: frame/kernel geometry defaults,
// derived output sizes and counter widths used by the feeder, the window
// generator and the convolution stages.
package cnn_pkg;

    // Pixel and frame geometry defaults
    localparam int unsigned I_F_BW = 8;
    localparam int unsigned IX     = 28;
    localparam int unsigned IY     = 28;
    localparam int unsigned KX     = 5;
    localparam int unsigned KY     = 5;

    // Valid-convolution output size (no padding, stride 1)
    localparam int unsigned OX = IX - KX + 1;
    localparam int unsigned OY = IY - KY + 1;

    // Position counter widths
    localparam int unsigned COL_W = $clog2(IX);
    localparam int unsigned ROW_W = $clog2(IY);

    // Bit offset of window element (r,c) inside a flattened KY*KX window
    function automatic int unsigned win_lsb(input int unsigned r,
                                            input int unsigned c,
                                            input int unsigned kx,
                                            input int unsigned bw);
        return (r * kx + c) * bw;
    endfunction

endpackage

// File: rtl/line_buffer_row.sv
// Single image-row delay line: each enabled write returns the sample that
// was written DEPTH enables earlier. Storage is a circular buffer so it maps
// onto SRL / distributed RAM; only the pointer is reset.
module line_buffer_row #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 28
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // The slot about to be overwritten holds the oldest sample
    assign dout_o = mem_q[ptr_q];

    // Advance the circular pointer on every enabled write
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    // Pointer register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Sample storage, contents are don't-care until a full row has passed
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming KY x KX sliding-window generator (stride 1, no padding).
// Raster-order pixels enter one per i_in_valid; KY-1 cascaded row delays
// supply the older rows, a register window shifts left per pixel, and every
// complete window is registered to the outputs one cycle after its last pixel.
module conv_window_gen #(
    parameter int unsigned I_F_BW = cnn_pkg::I_F_BW,
    parameter int unsigned IX     = cnn_pkg::IX,
    parameter int unsigned IY     = cnn_pkg::IY,
    parameter int unsigned KX     = cnn_pkg::KX,
    parameter int unsigned KY     = cnn_pkg::KY
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_in_valid,
    input  logic [I_F_BW-1:0]           i_pixel,
    output logic [KY*KX*I_F_BW-1:0]     o_window,
    output logic                        o_window_valid,
    output logic [$clog2(IY)-1:0]       o_win_row,
    output logic [$clog2(IX)-1:0]       o_win_col,
    output logic                        o_frame_done
);

    import cnn_pkg::*;

    localparam int unsigned CW = $clog2(IX);
    localparam int unsigned RW = $clog2(IY);
    localparam int unsigned WW = KY * KX * I_F_BW;

    localparam logic [CW-1:0] COL_LAST  = CW'(IX - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IY - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(KX - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(KY - 1);

    // Position of the incoming pixel
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Row delay chain and window storage
    logic [I_F_BW-1:0] lb_in   [KY-1];
    logic [I_F_BW-1:0] lb_out  [KY-1];
    logic [I_F_BW-1:0] col_src [KY];
    logic [I_F_BW-1:0] win_q   [KY][KX];
    logic [I_F_BW-1:0] win_d   [KY][KX];
    logic [WW-1:0]     window_d;

    // Registered outputs
    logic [WW-1:0] window_q;
    logic          valid_q;
    logic          done_q;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;

    logic win_ok;
    logic last_px;

    // Line buffers cascade from the newest row (KY-2) down to the oldest (0)
    for (genvar k = 0; k < KY - 1; k++) begin : g_lb
        if (k == KY - 2) begin : g_head
            assign lb_in[k] = i_pixel;
        end else begin : g_tail
            assign lb_in[k] = lb_out[k + 1];
        end

        line_buffer_row #(
            .W     (I_F_BW),
            .DEPTH (IX)
        ) u_row (
            .clk_i  (clk),
            .rst_ni (reset_n),
            .en_i   (i_in_valid),
            .din_i  (lb_in[k]),
            .dout_o (lb_out[k])
        );
    end

    // New right-hand column: buffered rows on top, live pixel at the bottom
    for (genvar r = 0; r < KY; r++) begin : g_src
        if (r == KY - 1) begin : g_live
            assign col_src[r] = i_pixel;
        end else begin : g_buf
            assign col_src[r] = lb_out[r];
        end
    end

    // Shifted window and its flattened image, used both for the window
    // register and for the output register so the output reflects the pixel
    // accepted in the same edge
    for (genvar r = 0; r < KY; r++) begin : g_wr
        for (genvar c = 0; c < KX; c++) begin : g_wc
            localparam int unsigned LSB = win_lsb(r, c, KX, I_F_BW);
            if (c == KX - 1) begin : g_new
                assign win_d[r][c] = col_src[r];
            end else begin : g_shift
                assign win_d[r][c] = win_q[r][c + 1];
            end
            assign window_d[LSB +: I_F_BW] = win_d[r][c];
        end
    end

    // Raster counters, window qualification and end-of-frame detection
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        win_ok    = 1'b0;
        last_px   = 1'b0;
        win_row_d = row_q - ROW_FIRST;
        win_col_d = col_q - COL_FIRST;
        if (i_in_valid) begin
            win_ok  = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
            last_px = (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Window shift register, unreset: gated downstream by the valid flag
    always_ff @(posedge clk) begin
        if (i_in_valid) begin
            win_q <= win_d;
        end
    end

    // Output registers; data and position hold while no window is produced
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            window_q  <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            win_row_q <= '0;
            win_col_q <= '0;
        end else begin
            valid_q <= win_ok;
            done_q  <= last_px;
            if (win_ok) begin
                window_q  <= window_d;
                win_row_q <= win_row_d;
                win_col_q <= win_col_d;
            end
        end
    end

    assign o_window       = window_q;
    assign o_window_valid = valid_q;
    assign o_win_row      = win_row_q;
    assign o_win_col      = win_col_q;
    assign o_frame_done   = done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: a 28x28/5x5 instance and an 8x8/3x3 instance,
// each stepped in lockstep against an image-array reference model.
module tb_conv_window_gen;

    logic clk = 1'b0;
    logic reset_n;

    // Default-geometry instance
    logic         m_valid;
    logic [7:0]   m_pix;
    logic [199:0] m_win;
    logic         m_wv;
    logic [4:0]   m_row;
    logic [4:0]   m_col;
    logic         m_done;

    // Small-geometry instance
    logic         s_valid;
    logic [7:0]   s_pix;
    logic [71:0]  s_win;
    logic         s_wv;
    logic [2:0]   s_row;
    logic [2:0]   s_col;
    logic         s_done;

    always #5 clk = ~clk;

    conv_window_gen u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_in_valid     (m_valid),
        .i_pixel        (m_pix),
        .o_window       (m_win),
        .o_window_valid (m_wv),
        .o_win_row      (m_row),
        .o_win_col      (m_col),
        .o_frame_done   (m_done)
    );

    conv_window_gen #(
        .I_F_BW (8),
        .IX     (8),
        .IY     (8),
        .KX     (3),
        .KY     (3)
    ) u_dut_small (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_in_valid     (s_valid),
        .i_pixel        (s_pix),
        .o_window       (s_win),
        .o_window_valid (s_wv),
        .o_win_row      (s_row),
        .o_win_col      (s_col),
        .o_frame_done   (s_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: current frame image plus raster position
    bit         sel;
    int         md_ix, md_iy, md_kx, md_ky;
    logic [7:0] img [28][28];
    int         mr, mc;
    logic [255:0] last_win;
    int         last_r, last_c;

    // Per-phase observations
    int           win_cnt, done_cnt, done_at, acc_idx, first_idx, second_idx;
    int           first_r, first_c, lst_r, lst_c;
    logic [255:0] first_win, second_first, lst_win;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] el(input logic [255:0] w, input int r, input int c, input int kx);
        return w[(r * kx + c) * 8 +: 8];
    endfunction

    task automatic new_stats();
        win_cnt = 0; done_cnt = 0; done_at = -1; acc_idx = 0;
        first_idx = -1; second_idx = -1;
    endtask

    task automatic model_reset();
        mr = 0; mc = 0; last_win = '0; last_r = 0; last_c = 0;
    endtask

    // Present one input cycle, then compare every output of the selected DUT
    task automatic cycle(input bit v, input logic [7:0] px);
        logic [255:0] ew, ow;
        int           er, ec, orow, ocol;
        bit           ev, ed;
        logic         ov, od;
        if (!sel) begin
            m_valid = v; m_pix = px; s_valid = 1'b0;
        end else begin
            s_valid = v; s_pix = px; m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        ev = 1'b0; ed = 1'b0; ew = last_win; er = last_r; ec = last_c;
        if (v) begin
            img[mr][mc] = px;
            if (mr >= md_ky - 1 && mc >= md_kx - 1) begin
                ev = 1'b1;
                ew = '0;
                for (int r = 0; r < md_ky; r++)
                    for (int c = 0; c < md_kx; c++)
                        ew[(r * md_kx + c) * 8 +: 8] = img[mr - md_ky + 1 + r][mc - md_kx + 1 + c];
                er = mr - md_ky + 1;
                ec = mc - md_kx + 1;
            end
            ed = (mr == md_iy - 1) && (mc == md_ix - 1);
            if (mc == md_ix - 1) begin
                mc = 0;
                mr = (mr == md_iy - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
        last_win = ew; last_r = er; last_c = ec;

        if (!sel) begin
            ov = m_wv; od = m_done; ow = 256'(m_win); orow = int'(m_row); ocol = int'(m_col);
        end else begin
            ov = s_wv; od = s_done; ow = 256'(s_win); orow = int'(s_row); ocol = int'(s_col);
        end
        check("window_valid", 256'(ov), 256'(ev));
        check("frame_done", 256'(od), 256'(ed));
        check("window", ow, ew);
        check("win_row", 256'(orow), 256'(er));
        check("win_col", 256'(ocol), 256'(ec));

        if (ov) begin
            if (win_cnt == 0) begin
                first_idx = acc_idx; first_win = ow; first_r = orow; first_c = ocol;
            end
            if (win_cnt == 576) begin
                second_idx = acc_idx; second_first = ow;
            end
            win_cnt++;
            lst_win = ow; lst_r = orow; lst_c = ocol;
        end
        if (od) begin
            done_cnt++;
            done_at = win_cnt;
        end
        if (v) acc_idx++;
    endtask

    initial begin
        bit v;
        int k;
        reset_n = 1'b0;
        m_valid = 1'b0; m_pix = '0; s_valid = 1'b0; s_pix = '0;
        sel = 1'b0;
        md_ix = 28; md_iy = 28; md_kx = 5; md_ky = 5;
        model_reset();

        // Reset values
        #2;
        check("rst_valid", 256'(m_wv), 256'(0));
        check("rst_done", 256'(m_done), 256'(0));
        check("rst_window", 256'(m_win), 256'(0));
        check("rst_row", 256'(m_row), 256'(0));
        check("rst_col", 256'(m_col), 256'(0));
        check("rst_s_window", 256'(s_win), 256'(0));
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        // Contiguous ramp frame
        new_stats();
        for (int i = 0; i < 784; i++) cycle(1'b1, 8'(i));
        cycle(1'b0, 8'h00);
        check("ramp_nwin", 256'(win_cnt), 256'(576));
        check("ramp_first_idx", 256'(first_idx), 256'(116));
        check("ramp_first_00", 256'(el(first_win, 0, 0, 5)), 256'(0));
        check("ramp_first_04", 256'(el(first_win, 0, 4, 5)), 256'(4));
        check("ramp_first_40", 256'(el(first_win, 4, 0, 5)), 256'(112));
        check("ramp_first_44", 256'(el(first_win, 4, 4, 5)), 256'(116));
        check("ramp_first_rc", 256'({first_r, first_c}), 256'({32'd0, 32'd0}));
        check("ramp_last_44", 256'(el(lst_win, 4, 4, 5)), 256'(15));
        check("ramp_last_rc", 256'({lst_r, lst_c}), 256'({32'd23, 32'd23}));
        check("ramp_ndone", 256'(done_cnt), 256'(1));
        check("ramp_done_at", 256'(done_at), 256'(576));

        // Same ramp with ~40% input gaps
        new_stats();
        k = 0;
        while (k < 784) begin
            v = ($urandom_range(0, 99) >= 40);
            cycle(v, v ? 8'(k) : 8'($urandom));
            if (v) k++;
        end
        cycle(1'b0, 8'h00);
        check("gap_nwin", 256'(win_cnt), 256'(576));
        check("gap_first_idx", 256'(first_idx), 256'(116));
        check("gap_ndone", 256'(done_cnt), 256'(1));
        check("gap_done_at", 256'(done_at), 256'(576));

        // Two back-to-back frames, second one inverted ramp
        new_stats();
        for (int i = 0; i < 1568; i++)
            cycle(1'b1, (i < 784) ? 8'(i) : 8'(255 - (i - 784)));
        cycle(1'b0, 8'h00);
        check("b2b_nwin", 256'(win_cnt), 256'(1152));
        check("b2b_ndone", 256'(done_cnt), 256'(2));
        check("b2b_f2_idx", 256'(second_idx), 256'(900));
        check("b2b_f2_00", 256'(el(second_first, 0, 0, 5)), 256'(255));
        check("b2b_f2_44", 256'(el(second_first, 4, 4, 5)), 256'(139));

        // Reset pulse mid-frame
        new_stats();
        for (int i = 0; i < 300; i++) cycle(1'b1, 8'(i));
        reset_n = 1'b0;
        #2;
        check("async_rst_valid", 256'(m_wv), 256'(0));
        check("async_rst_window", 256'(m_win), 256'(0));
        check("async_rst_row", 256'(m_row), 256'(0));
        check("async_rst_col", 256'(m_col), 256'(0));
        for (int i = 0; i < 3; i++) begin
            m_valid = 1'b1; m_pix = 8'($urandom);
            @(posedge clk);
            #1;
            check("in_rst_valid", 256'(m_wv), 256'(0));
        end
        m_valid = 1'b0;
        reset_n = 1'b1;
        model_reset();
        new_stats();
        for (int i = 0; i < 784; i++) cycle(1'b1, 8'(i));
        cycle(1'b0, 8'h00);
        check("rst_nwin", 256'(win_cnt), 256'(576));
        check("rst_first_idx", 256'(first_idx), 256'(116));
        check("rst_ndone", 256'(done_cnt), 256'(1));

        // Small geometry: 8x8 frame, 3x3 window
        sel = 1'b1;
        md_ix = 8; md_iy = 8; md_kx = 3; md_ky = 3;
        model_reset();
        new_stats();
        for (int i = 0; i < 64; i++) cycle(1'b1, 8'(i));
        cycle(1'b0, 8'h00);
        check("small_nwin", 256'(win_cnt), 256'(36));
        check("small_first_idx", 256'(first_idx), 256'(18));
        check("small_first_22", 256'(el(first_win, 2, 2, 3)), 256'(18));
        check("small_ndone", 256'(done_cnt), 256'(1));
        check("small_done_at", 256'(done_at), 256'(36));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
